// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the write-back port arbiter, plus the round-robin
// index arithmetic used by the grant logic.
package wb_port_arbiter_pkg;

    localparam int CPU_NUM_REQ    = 8;
    localparam int CPU_REG_ID_BIT = 4;
    localparam int CPU_REG_BIT    = 16;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back bus between the functional units and the register-file port.
// slave: the arbiter's view; master: the requesters / register file side.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = CPU_NUM_REQ,
    parameter int REG_ID_BIT = CPU_REG_ID_BIT,
    parameter int REG_BIT    = CPU_REG_BIT,
    parameter int SRC_BIT    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ*REG_ID_BIT-1:0] req_reg_id;
    logic [NUM_REQ*REG_BIT-1:0]    req_data;
    logic                          out_vld;
    logic                          out_rdy;
    logic [REG_ID_BIT-1:0]         out_reg_id;
    logic [REG_BIT-1:0]            out_data;
    logic [SRC_BIT-1:0]            out_src;
    logic                          idle;

    modport slave (
        input  req_vld, req_reg_id, req_data, out_rdy,
        output req_rdy, out_vld, out_reg_id, out_data, out_src, idle
    );

    modport master (
        output req_vld, req_reg_id, req_data, out_rdy,
        input  req_rdy, out_vld, out_reg_id, out_data, out_src, idle
    );
endinterface

// File: rtl/wb_port_arbiter_rr_priority.sv
// Round-robin priority picker: the requester just after last_grant has the
// highest priority, last_grant itself the lowest.
module rr_priority
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CPU_NUM_REQ,
    parameter int SRC_BIT = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SRC_BIT-1:0] last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [SRC_BIT-1:0] grant_idx_o,
    output logic               grant_vld_o
);
    logic [SRC_BIT-1:0] pos_s;

    // Scan from last_grant+1 upward with wrap; the first active request wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        pos_s       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos_s = SRC_BIT'(rr_wrap(int'(last_grant_i), k, NUM_REQ));
            if (!grant_vld_o && req_i[pos_s]) begin
                grant_o[pos_s] = 1'b1;
                grant_idx_o    = pos_s;
                grant_vld_o    = 1'b1;
            end else begin
                grant_vld_o = grant_vld_o;
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: N functional units share one register-file write
// port through a single registered output entry, granted round-robin.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = CPU_NUM_REQ,
    parameter int REG_ID_BIT = CPU_REG_ID_BIT,
    parameter int REG_BIT    = CPU_REG_BIT,
    parameter int SRC_BIT    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);
    logic                  out_vld_q,    out_vld_d;
    logic [REG_ID_BIT-1:0] out_reg_id_q, out_reg_id_d;
    logic [REG_BIT-1:0]    out_data_q,   out_data_d;
    logic [SRC_BIT-1:0]    out_src_q,    out_src_d;
    logic [SRC_BIT-1:0]    last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]    grant_s;
    logic [SRC_BIT-1:0]    grant_idx_s;
    logic                  grant_vld_s;
    logic                  slot_free_s;
    logic                  xfer_s;
    logic [REG_ID_BIT-1:0] sel_reg_id_s;
    logic [REG_BIT-1:0]    sel_data_s;

    rr_priority #(
        .NUM_REQ (NUM_REQ),
        .SRC_BIT (SRC_BIT)
    ) u_rr_priority (
        .req_i        (bus.req_vld),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s),
        .grant_idx_o  (grant_idx_s),
        .grant_vld_o  (grant_vld_s)
    );

    // Handshake: accept only when the entry is empty or draining this cycle.
    always_comb begin
        slot_free_s = !out_vld_q || bus.out_rdy;
        xfer_s      = slot_free_s && grant_vld_s;
        bus.req_rdy = slot_free_s ? grant_s : '0;
        bus.idle    = !out_vld_q && !(|bus.req_vld);
    end

    // Payload mux: one-hot grant selects the winning requester's id and data.
    always_comb begin
        sel_reg_id_s = '0;
        sel_data_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_reg_id_s = sel_reg_id_s
                         | ({REG_ID_BIT{grant_s[i]}} & bus.req_reg_id[i*REG_ID_BIT +: REG_ID_BIT]);
            sel_data_s   = sel_data_s
                         | ({REG_BIT{grant_s[i]}} & bus.req_data[i*REG_BIT +: REG_BIT]);
        end
    end

    // Next state: load on transfer, empty on drain, otherwise hold.
    always_comb begin
        out_vld_d    = out_vld_q;
        out_reg_id_d = out_reg_id_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (xfer_s) begin
            out_vld_d    = 1'b1;
            out_reg_id_d = sel_reg_id_s;
            out_data_d   = sel_data_s;
            out_src_d    = grant_idx_s;
            last_grant_d = grant_idx_s;
        end else if (bus.out_rdy) begin
            out_vld_d    = 1'b0;
        end else begin
            out_vld_d    = out_vld_q;
        end
    end

    // State registers; reset leaves requester 0 at highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q    <= 1'b0;
            out_reg_id_q <= '0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_BIT'(NUM_REQ - 1);
        end else begin
            out_vld_q    <= out_vld_d;
            out_reg_id_q <= out_reg_id_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_vld    = out_vld_q;
    assign bus.out_reg_id = out_reg_id_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, giving the number of write-back requesters (functional units).
REQ-002 The block SHALL have parameter REG_ID_BIT, default 4, giving the destination register id width.
REQ-003 The block SHALL have parameter REG_BIT, default 16, giving the data width.
REQ-004 The block SHALL have parameter SRC_BIT, default $clog2(NUM_REQ), giving the source id width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req_vld, input, NUM_REQ bits: per-requester write-back valid.
REQ-008 The block SHALL have port req_rdy, output, NUM_REQ bits: per-requester accept.
REQ-009 The block SHALL have port req_reg_id, input, NUM_REQ*REG_ID_BIT bits: packed destination ids, requester i at [i*REG_ID_BIT +: REG_ID_BIT].
REQ-010 The block SHALL have port req_data, input, NUM_REQ*REG_BIT bits: packed write data, same packing.
REQ-011 The block SHALL have port out_vld, output, 1 bit: register-file write valid.
REQ-012 The block SHALL have port out_rdy, input, 1 bit: register-file write accept.
REQ-013 The block SHALL have port out_reg_id, output, REG_ID_BIT bits: granted destination id.
REQ-014 The block SHALL have port out_data, output, REG_BIT bits: granted data.
REQ-015 The block SHALL have port out_src, output, SRC_BIT bits: index of the granted requester.
REQ-016 The block SHALL have port idle, output, 1 bit: high when out_vld=0 and req_vld is all zero.

Function
REQ-017 The block SHALL hold one output entry (out_vld/out_reg_id/out_data/out_src registers) and SHALL accept a request only when out_vld=0 or out_rdy=1 (slot free or draining).
REQ-018 The block SHALL grant round-robin: priority starts at (last_grant+1) mod NUM_REQ and proceeds upward with wrap-around; the lowest-priority requester is last_grant itself.
REQ-019 req_rdy SHALL be one-hot or zero, asserted only for the granted requester, combinationally from req_vld, last_grant, out_vld and out_rdy.
REQ-020 On a transfer (req_vld[i] && req_rdy[i]), the next cycle SHALL present out_vld=1, out_reg_id/out_data of requester i and out_src=i; latency 1 cycle.
REQ-021 last_grant SHALL update to i only on a transfer; stall cycles SHALL NOT move the pointer.
REQ-022 While out_vld=1 and out_rdy=0, all out_* SHALL be held stable and req_rdy SHALL be all zero.
REQ-023 On out_rdy=1 with no request pending, out_vld SHALL fall to 0 the next cycle.
REQ-024 Simultaneous drain and accept SHALL give back-to-back transfers: one write per cycle sustained.
REQ-025 The block SHALL not drop or duplicate entries; a requester continuously asserting req_vld SHALL be granted within NUM_REQ transfers.
REQ-026 Requesters SHALL hold req_vld and payload stable until accepted; the block's behaviour is undefined otherwise.

Reset
REQ-027 During rst_n=0: out_vld=0, out_reg_id=0, out_data=0, out_src=0, last_grant=NUM_REQ-1 (requester 0 highest priority); req_rdy therefore all zero until first request.
REQ-028 Reset asserted mid-transfer SHALL discard the held entry immediately (asynchronously).

Structure
REQ-029 NUM_REQ, REG_ID_BIT and REG_BIT defaults SHALL come from the shared cpu package constants; no new typedefs are required.
REQ-030 The round-robin grant logic SHALL be one sub-module, rr_priority (inputs request vector and last_grant, outputs one-hot grant and encoded index).

Verification
REQ-031 Reset, req_vld=0x00 -> out_vld=0, req_rdy=0x00, idle=1.
REQ-032 req_vld=0xFF, out_rdy=1 for 8 cycles -> out_src sequence 0,1,2,...,7, one per cycle, out_data matching each requester.
REQ-033 req_vld[3] with data 0x1234 reg 5, out_rdy=0 for 3 cycles -> out_vld=1, out_reg_id=5, out_data=0x1234 held; req_rdy=0x00 throughout; transfer completes on out_rdy=1.
REQ-034 last_grant=6, req_vld=0x41 (requesters 0 and 6) -> 0 granted first, then 6 (wrap-around).
REQ-035 req_vld[2] held constant while requesters 0,1,3 churn -> requester 2 granted within 8 transfers.
REQ-036 rst_n pulsed low while out_vld=1 -> out_vld=0 immediately; after release requester 0 has highest priority.
